// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: latest period/high measurement and line status.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 32
);
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_valid;
  logic             o_ovf;
  logic             o_stuck;
  logic             o_level;

  modport master (output o_period, o_high, o_valid, o_ovf, o_stuck, o_level);
  modport slave  (input  o_period, o_high, o_valid, o_ovf, o_stuck, o_level);
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM line in i_clk counts,
// and flags a line that has stopped toggling.
module pwm_capture #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_pwm,
  pwm_capture_if.master res
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ICNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             rise, fall, edge_det;
  logic [CNT_W-1:0] pcnt, pcnt_nx;
  logic [CNT_W-1:0] hcnt, hcnt_nx;
  logic [CNT_W-1:0] icnt, icnt_nx;
  logic             publish, expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Synchronizer runs regardless of i_en so re-enabling never sees a stale edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_pwm;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise        = s2 & ~s3;
  assign fall        = ~s2 & s3;
  assign edge_det    = rise | fall;
  assign res.o_level = s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    hcnt_nx  = hcnt;
    icnt_nx  = icnt;
    publish  = 1'b0;
    expire   = 1'b0;

    // An edge always restarts the idle count, so it beats a coincident timeout.
    if (edge_det)                icnt_nx = '0;
    else if (icnt == ICNT_LAST)  expire  = 1'b1;
    else                         icnt_nx = icnt + CNT_ONE;

    case (state)
      IDLE: begin
        pcnt_nx = '0;
        hcnt_nx = '0;
        if (rise) begin
          state_nx = HIGH;
          hcnt_nx  = CNT_ONE;
        end
      end
      HIGH: begin
        pcnt_nx = sat_inc(pcnt);
        if (fall) state_nx = LOW;
        else      hcnt_nx  = sat_inc(hcnt);
      end
      LOW: begin
        if (rise) begin
          publish  = 1'b1;
          state_nx = HIGH;
          pcnt_nx  = '0;
          hcnt_nx  = CNT_ONE;
        end else begin
          pcnt_nx  = sat_inc(pcnt);
        end
      end
      default: state_nx = IDLE;
    endcase

    if (expire) begin
      state_nx = IDLE;
      pcnt_nx  = '0;
      hcnt_nx  = '0;
    end

    if (!i_en) begin
      state_nx = IDLE;
      pcnt_nx  = '0;
      hcnt_nx  = '0;
      icnt_nx  = '0;
      publish  = 1'b0;
      expire   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pcnt         <= '0;
      hcnt         <= '0;
      icnt         <= '0;
      res.o_period <= '0;
      res.o_high   <= '0;
      res.o_valid  <= 1'b0;
      res.o_ovf    <= 1'b0;
      res.o_stuck  <= 1'b0;
    end else begin
      pcnt        <= pcnt_nx;
      hcnt        <= hcnt_nx;
      icnt        <= icnt_nx;
      res.o_valid <= publish;

      if (!i_en)         res.o_stuck <= 1'b0;
      else if (expire)   res.o_stuck <= 1'b1;
      else if (edge_det) res.o_stuck <= 1'b0;

      // Period includes the restart cycle itself, hence the +1 on pcnt.
      if (publish) begin
        res.o_period <= sat_inc(pcnt);
        res.o_high   <= hcnt;
        res.o_ovf    <= (pcnt == CNT_MAX) || (hcnt == CNT_MAX);
      end else if (expire) begin
        res.o_period <= '0;
        res.o_high   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of synchronous PWM patterns plus
// hand-written latency, switch, timeout, reset and enable sequences.
module tb_pwm_capture;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_en;
  logic i_pwm;

  always #5 i_clk = ~i_clk;

  pwm_capture_if #(.CNT_W(32)) a_if ();
  pwm_capture_if #(.CNT_W(32)) b_if ();
  pwm_capture_if #(.CNT_W(8))  c_if ();

  pwm_capture #(.CNT_W(32), .TIMEOUT(2000)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_pwm(i_pwm), .res(a_if)
  );
  pwm_capture #(.CNT_W(32), .TIMEOUT(64)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_pwm(i_pwm), .res(b_if)
  );
  pwm_capture #(.CNT_W(8), .TIMEOUT(250)) dut_c (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_pwm(i_pwm), .res(c_if)
  );

  typedef struct {
    int unsigned p;
    int unsigned h;
    logic        ovf;
  } exp_t;

  typedef struct {
    int unsigned p;
    int unsigned h;
    int unsigned n;
    int unsigned sel;
    int unsigned ep;
    int unsigned eh;
    logic        eovf;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  vec_t vecs[8];
  logic chk_a, chk_b, chk_c;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic mon(input int unsigned which, input logic v, input logic [31:0] p,
                     input logic [31:0] h, input logic o);
    exp_t  e;
    logic  en_chk;
    logic  have;
    string tag;
    case (which)
      0:       begin en_chk = chk_a; have = (qa.size() > 0); tag = "a"; end
      1:       begin en_chk = chk_b; have = (qb.size() > 0); tag = "b"; end
      default: begin en_chk = chk_c; have = (qc.size() > 0); tag = "c"; end
    endcase
    if (!en_chk || v !== 1'b1) return;
    if (!have) begin
      check({tag, "_unexpected_valid"}, 32'(v), 32'd0);
      return;
    end
    case (which)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    check({tag, "_period"}, p, e.p);
    check({tag, "_high"}, h, e.h);
    check({tag, "_ovf"}, 32'(o), 32'(e.ovf));
  endtask

  task automatic step(input logic v);
    i_pwm = v;
    @(posedge i_clk);
    #1;
    mon(0, a_if.o_valid, a_if.o_period, a_if.o_high, a_if.o_ovf);
    mon(1, b_if.o_valid, b_if.o_period, b_if.o_high, b_if.o_ovf);
    mon(2, c_if.o_valid, 32'(c_if.o_period), 32'(c_if.o_high), c_if.o_ovf);
  endtask

  task automatic run_pwm(input int unsigned p, input int unsigned h, input int unsigned n,
                         input int unsigned sel, input int unsigned ep, input int unsigned eh,
                         input logic eovf);
    exp_t e;
    e.p   = ep;
    e.h   = eh;
    e.ovf = eovf;
    for (int unsigned k = 0; k < n; k++) begin
      case (sel)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
      for (int unsigned i = 0; i < h; i++) step(1'b1);
      for (int unsigned i = h; i < p; i++) step(1'b0);
    end
  endtask

  // Closing rise publishes the last driven period; then every expectation must be consumed.
  task automatic finish_group(input string name);
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    check({name, "_pending"}, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  task automatic idle_clear();
    i_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    i_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
  endtask

  initial begin
    logic [3:0] vb;

    vecs[0] = '{p: 100, h: 50,  n: 4, sel: 0, ep: 100, eh: 50,  eovf: 1'b0};
    vecs[1] = '{p: 40,  h: 10,  n: 3, sel: 0, ep: 40,  eh: 10,  eovf: 1'b0};
    vecs[2] = '{p: 4,   h: 2,   n: 5, sel: 0, ep: 4,   eh: 2,   eovf: 1'b0};
    vecs[3] = '{p: 7,   h: 3,   n: 3, sel: 0, ep: 7,   eh: 3,   eovf: 1'b0};
    vecs[4] = '{p: 300, h: 100, n: 2, sel: 2, ep: 255, eh: 100, eovf: 1'b1};
    vecs[5] = '{p: 200, h: 60,  n: 2, sel: 2, ep: 200, eh: 60,  eovf: 1'b0};
    vecs[6] = '{p: 256, h: 128, n: 2, sel: 2, ep: 255, eh: 128, eovf: 1'b1};
    vecs[7] = '{p: 255, h: 200, n: 2, sel: 2, ep: 255, eh: 200, eovf: 1'b0};

    chk_a = 1'b0;
    chk_b = 1'b0;
    chk_c = 1'b0;
    i_rst = 1'b1;
    i_en  = 1'b0;
    i_pwm = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_period", a_if.o_period, 32'd0);
    check("rst_high",   a_if.o_high,   32'd0);
    check("rst_valid",  32'(a_if.o_valid), 32'd0);
    check("rst_ovf",    32'(a_if.o_ovf),   32'd0);
    check("rst_stuck",  32'(a_if.o_stuck), 32'd0);
    check("rst_level",  32'(a_if.o_level), 32'd0);
    i_rst = 1'b0;

    for (int unsigned t = 0; t < 8; t++) begin
      idle_clear();
      chk_a = (vecs[t].sel == 0);
      chk_b = 1'b0;
      chk_c = (vecs[t].sel == 2);
      run_pwm(vecs[t].p, vecs[t].h, vecs[t].n, vecs[t].sel, vecs[t].ep, vecs[t].eh, vecs[t].eovf);
      finish_group($sformatf("vec%0d", t));
    end
    chk_c = 1'b0;

    // Latency: o_valid high exactly after the second edge following the first high sample.
    idle_clear();
    chk_a = 1'b1;
    run_pwm(100, 50, 1, 0, 100, 50, 1'b0);
    vb = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      step(1'b1);
      vb[k] = a_if.o_valid;
    end
    check("latency_valid_bits", 32'(vb), 32'h4);
    finish_group("latency");

    // Period switch chain: 1000/500 -> 40/10 -> 4/2 on cycle boundaries.
    idle_clear();
    run_pwm(1000, 500, 2, 0, 1000, 500, 1'b0);
    run_pwm(40, 10, 3, 0, 40, 10, 1'b0);
    run_pwm(4, 2, 3, 0, 4, 2, 1'b0);
    finish_group("switch");
    check("switch_final_period", a_if.o_period, 32'd4);

    // Stuck-high on the TIMEOUT=64 instance, then resume.
    idle_clear();
    chk_a = 1'b0;
    chk_b = 1'b1;
    run_pwm(20, 10, 2, 1, 20, 10, 1'b0);
    for (int unsigned k = 0; k < 70; k++) begin
      step(1'b1);
      if (k == 65) check("stuck_before_64", 32'(b_if.o_stuck), 32'd0);
      if (k == 66) check("stuck_at_64",     32'(b_if.o_stuck), 32'd1);
    end
    check("stuck_pending", 32'(qb.size()), 32'd0);
    check("stuck_level",  32'(b_if.o_level), 32'd1);
    check("stuck_period", b_if.o_period, 32'd0);
    check("stuck_high",   b_if.o_high,   32'd0);
    step(1'b0);
    step(1'b0);
    check("stuck_held_until_fall", 32'(b_if.o_stuck), 32'd1);
    step(1'b0);
    check("stuck_cleared_by_fall", 32'(b_if.o_stuck), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0);
    run_pwm(20, 10, 2, 1, 20, 10, 1'b0);
    finish_group("resume");
    chk_b = 1'b0;

    // Asynchronous reset in the middle of a high phase.
    idle_clear();
    chk_a = 1'b1;
    run_pwm(100, 50, 1, 0, 100, 50, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);
    check("prereset_period", a_if.o_period, 32'd100);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_period", a_if.o_period, 32'd0);
    check("arst_high",   a_if.o_high,   32'd0);
    check("arst_level",  32'(a_if.o_level), 32'd0);
    check("arst_valid",  32'(a_if.o_valid), 32'd0);
    i_pwm = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    qa.delete();
    for (int i = 0; i < 5; i++) step(1'b0);
    run_pwm(30, 15, 2, 0, 30, 15, 1'b0);
    finish_group("post_reset");

    // Enable dropped mid-LOW: outputs hold, capture restarts from IDLE.
    idle_clear();
    run_pwm(100, 50, 2, 0, 100, 50, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    i_en = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0);
    check("en_hold_period", a_if.o_period, 32'd100);
    check("en_hold_high",   a_if.o_high,   32'd50);
    check("en_hold_ovf",    32'(a_if.o_ovf), 32'd0);
    i_en = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0);
    run_pwm(60, 20, 1, 0, 60, 20, 1'b0);
    finish_group("en_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture block: the receiving end of the motor/buzzer PWM link driven by the PWM generator. It samples one asynchronous PWM line in the `i_clk` domain and measures each complete cycle. For every cycle it publishes the period and high time in clock counts. It also flags a stalled line (0 % / 100 % duty or a dead driver) so the memory/control logic can verify the commanded speed against the actual waveform.

## Interface
- `CNT_W`, 32: width of period/high counters and outputs.
- `TIMEOUT`, 1_000_000: cycles without any detected edge before the line is declared stuck. Must be ≥ 2 and < 2^CNT_W.
- `i_clk`  in  1: system clock (100 MHz in the current build).
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_en`  in  1: capture enable; low = synchronous clear to IDLE.
- `i_pwm`  in  1: PWM line, asynchronous to `i_clk`.
- `o_period`  out  CNT_W: last measured period, in clocks.
- `o_high`  out  CNT_W: last measured high time, in clocks.
- `o_valid`  out  1: one-cycle pulse when `o_period`/`o_high` update.
- `o_ovf`  out  1: last published measurement saturated.
- `o_stuck`  out  1: no edge for TIMEOUT cycles; level-sensitive.
- `o_level`  out  1: synchronized line level, meaningful when stuck.

## Operation
- Synchronizer: `s1 <= i_pwm`, `s2 <= s1`, `s3 <= s2`. `rise = s2 & ~s3`, `fall = ~s2 & s3`. Only `s2` and `s3` are used downstream.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: counters held at 0. On `rise`, go to HIGH with `pcnt <= 0` and `hcnt <= 1`. Nothing is published, because the first rise has no prior reference.
  - HIGH: `pcnt` increments every cycle. `hcnt` increments every cycle. On `fall`, go to LOW.
  - LOW: `pcnt` increments and `hcnt` holds. On `rise`, publish, then restart with `pcnt <= 0`, `hcnt <= 1`, and go to HIGH.
- Publish (registered, same edge as restart):
  - `o_period <= sat(pcnt+1)`
  - `o_high <= hcnt`
  - `o_ovf <=` 1 if either counter reached 2^CNT_W−1 during the cycle, else 0
  - `o_valid <= 1` for exactly one cycle
- Saturation: `pcnt` and `hcnt` stop at 2^CNT_W−1 and never wrap.
- Timeout: `icnt` counts cycles since the last `rise` or `fall`, and clears on either. When `icnt` reaches TIMEOUT−1 with no edge:
  - `o_stuck <= 1`
  - `o_period <= 0`, `o_high <= 0`
  - FSM goes to IDLE
  - no `o_valid` pulse
- Leaving stuck: `o_stuck` clears on the next `rise` or `fall`. The next publish needs two further rises.
- `o_level = s2`, continuously.
- `i_en` low: FSM goes to IDLE; `pcnt`, `hcnt`, `icnt`, `o_valid`, `o_stuck` all go to 0. `o_period`, `o_high`, `o_ovf` hold their values. The synchronizer keeps running.
- Simultaneous events:
  - `rise` and timeout in the same cycle: `rise` wins (edge resets `icnt`, publish happens if in LOW).
  - `i_en` low overrides everything.
- Glitch handling: none; a pulse shorter than one clock may be missed. Required minimum high and low time is 2 clocks.

## Timing
- Reset values: `o_period`=0, `o_high`=0, `o_valid`=0, `o_ovf`=0, `o_stuck`=0, `o_level`=0. All internal state is 0 and the FSM is in IDLE.
- Latency: `i_pwm` rising, first sampled high at clock edge N, gives `o_valid`=1 after edge N+2, i.e. during cycle N+2..N+3.
- Measurement accuracy: for a synchronous input with period P and high time H clocks, `o_period`=P and `o_high`=H exactly. For an asynchronous input the error is ±1 clock.
- `o_valid` pulses are separated by at least 4 cycles at the minimum legal period.
- Reset mid-cycle: all outputs clear immediately. After release, the first `o_valid` follows the second detected rise.

## Test plan
- Synchronous PWM, P=100, H=50, 5 cycles after reset:
  - no `o_valid` on the first rise;
  - then 4 pulses, each with `o_period`=100, `o_high`=50, `o_ovf`=0;
  - first pulse 2 edges after the second rise is sampled.
- Period switch from P=1000/H=500 to P=40/H=10 on a cycle boundary: the published values change at the next `o_valid` with no intermediate value. Repeat with min-legal P=4, H=2.
- `i_pwm` held high with TIMEOUT=64: `o_stuck`=1 exactly 64 cycles after the last `rise`, `o_level`=1, `o_period`=`o_high`=0. Resume with P=20: `o_stuck` clears on the first edge and `o_valid` appears after the second rise.
- CNT_W=8, P=300, H=100: `o_period`=255, `o_high`=100, `o_ovf`=1. Then P=200: `o_ovf`=0.
- Assert `i_rst` asynchronously mid-HIGH: outputs are 0 before the next clock edge. Drop `i_en` for 10 cycles mid-LOW: no `o_valid`, `o_period` holds, and capture restarts from IDLE.
